mod_counter: RTL and testbench

- Parametrised modulo-N up/down counter.
- Adds the following to the basic 4-bit free-running counter:
  - configurable width and modulus
  - count enable and direction control
  - synchronous clear and parallel load
  - wrap or saturate mode
  - terminal-count and overflow/underflow flags
- Serves as the standard counting primitive for lab timers, dividers and display scanners in this codebase.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/mod_counter_next.sv | 61 ++++++
 rtl/mod_counter.sv | 68 ++++++
 tb/tb_mod_counter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counting primitives: saturate/wrap mode codes
// and a helper that sizes a bus to hold 0..MOD-1.
package counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Number of bits needed to represent modulus-1 (never less than 1).
    function automatic int cnt_width(input longint unsigned modulus);
        longint unsigned top;
        int w;
        top = (modulus > 1) ? modulus - 1 : 0;
        w = 1;
        while (w < 64 && (top >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Next-state logic for mod_counter: priority clr > load > en, with clamp on
// load and wrap or saturate at the bounds. Purely combinational.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MOD      = 16,
    parameter int              SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_q,
    output logic             next_ovf,
    output logic             next_udf
);

    // Bounds are compared one bit wider than q so MOD = 2**WIDTH cannot truncate.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MOD - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] lv_ext;
    logic           at_top;
    logic           at_bot;

    assign q_ext  = {1'b0, q};
    assign lv_ext = {1'b0, load_val};
    assign at_top = (q_ext == TOP);
    assign at_bot = (q_ext == '0);

    always_comb begin
        next_q   = q;
        next_ovf = 1'b0;
        next_udf = 1'b0;
        if (clr) begin
            next_q = '0;
        end else if (load) begin
            next_q = (lv_ext > TOP) ? TOP[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    next_ovf = 1'b1;
                    next_q   = (SATURATE == CNT_MODE_SAT) ? q : '0;
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    next_udf = 1'b1;
                    next_q   = (SATURATE == CNT_MODE_SAT) ? q : TOP[WIDTH-1:0];
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter: register stage around
// mod_counter_next, plus the combinational terminal-count output for cascading.
module mod_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MOD      = 16,
    parameter int              SATURATE = CNT_MODE_WRAP,
    parameter longint unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MOD - 1);

    if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || cnt_width(MOD) > WIDTH ||
        RST_VAL >= MOD ||
        (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT)) begin : g_bad_params
        $error("mod_counter: illegal parameters WIDTH=%0d MOD=%0d RST_VAL=%0d SATURATE=%0d",
               WIDTH, MOD, RST_VAL, SATURATE);
    end

    logic [WIDTH-1:0] next_q;
    logic             next_ovf;
    logic             next_udf;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q),
        .up       (up),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .next_q   (next_q),
        .next_ovf (next_ovf),
        .next_udf (next_udf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= WIDTH'(RST_VAL);
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            q   <= next_q;
            ovf <= next_ovf;
            udf <= next_udf;
        end
    end

    // Terminal count feeds the next stage's en, so it must not wait for a clock.
    assign tc = en & ((up & ({1'b0, q} == TOP)) | (~up & (q == '0)));

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: three instances (MOD=10 wrap, MOD=10
// saturate with RST_VAL=2, MOD=16 wrap) driven from a vector table and a scoreboard.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en, up, clr, load;
    logic [3:0] load_val [3];
    logic [3:0] q [3];
    logic [2:0] tc, ovf, udf;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .RST_VAL(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en[0]), .up(up[0]), .clr(clr[0]), .load(load[0]),
        .load_val(load_val[0]), .q(q[0]), .tc(tc[0]), .ovf(ovf[0]), .udf(udf[0]));

    mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1), .RST_VAL(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en[1]), .up(up[1]), .clr(clr[1]), .load(load[1]),
        .load_val(load_val[1]), .q(q[1]), .tc(tc[1]), .ovf(ovf[1]), .udf(udf[1]));

    mod_counter #(.WIDTH(4), .MOD(16), .SATURATE(0), .RST_VAL(0)) dut_full (
        .clk(clk), .rst(rst), .en(en[2]), .up(up[2]), .clr(clr[2]), .load(load[2]),
        .load_val(load_val[2]), .q(q[2]), .tc(tc[2]), .ovf(ovf[2]), .udf(udf[2]));

    typedef struct {
        int         id;
        int         dut;
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] exp_q;
        logic       exp_ovf;
        logic       exp_udf;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic c, input logic l, input logic [3:0] lv,
                                input logic e, input logic u, input logic [3:0] eq,
                                input logic eo, input logic eu, input logic et);
        vec_t v;
        v.id = vecs.size(); v.dut = d; v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
        v.exp_q = eq; v.exp_ovf = eo; v.exp_udf = eu; v.exp_tc = et;
        return v;
    endfunction

    task automatic idleInputs();
        en = '0; up = '0; clr = '0; load = '0;
        for (int k = 0; k < 3; k++) load_val[k] = '0;
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d dut%0d q", e.id, e.dut), 32'(q[e.dut]), 32'(e.exp_q));
            check($sformatf("v%0d dut%0d ovf", e.id, e.dut), 32'(ovf[e.dut]), 32'(e.exp_ovf));
            check($sformatf("v%0d dut%0d udf", e.id, e.dut), 32'(udf[e.dut]), 32'(e.exp_udf));
        end
    endtask

    // Drive on the falling edge, check tc before the rising edge, registers after it.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        idleInputs();
        en[v.dut] = v.en; up[v.dut] = v.up; clr[v.dut] = v.clr; load[v.dut] = v.load;
        load_val[v.dut] = v.lv;
        #1;
        check($sformatf("v%0d dut%0d tc", v.id, v.dut), 32'(tc[v.dut]), 32'(v.exp_tc));
        sb.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b0;
        idleInputs();

        //          dut clr load lv  en up   q  ovf udf tc
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4'((i + 1) % 10), i == 9, 0, i == 9));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 9, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 8, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 5,  0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 14, 0, 0, 9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2,  1, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8,  0, 0, 8, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 1, 9, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 1, 9, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 9, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(2, 0, 1, 15, 0, 0, 15, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0,  1, 1, 0, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0,  1, 0, 15, 0, 1, 1));

        #12;
        check("reset q0", 32'(q[0]), 32'd0);
        check("reset q1", 32'(q[1]), 32'd2);
        check("reset q2", 32'(q[2]), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset udf", 32'(udf), 32'd0);
        check("reset tc", 32'(tc), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Async reset mid-count: dut0 counting at 6, dut2 holding an ovf pulse.
        @(negedge clk);
        idleInputs();
        load[0] = 1'b1; load_val[0] = 4'd5;
        load[1] = 1'b1; load_val[1] = 4'd7;
        @(negedge clk);
        idleInputs();
        en[0] = 1'b1; up[0] = 1'b1;
        en[2] = 1'b1; up[2] = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset q0", 32'(q[0]), 32'd6);
        check("pre-reset q1", 32'(q[1]), 32'd7);
        check("pre-reset ovf2", 32'(ovf[2]), 32'd1);
        @(negedge clk);
        en[2] = 1'b0;
        rst = 1'b0;
        #1;
        check("async q0", 32'(q[0]), 32'd0);
        check("async q1", 32'(q[1]), 32'd2);
        check("async q2", 32'(q[2]), 32'd0);
        check("async ovf", 32'(ovf), 32'd0);
        check("async udf", 32'(udf), 32'd0);
        @(posedge clk);
        #1;
        check("held-in-reset q0", 32'(q[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("resume q0", 32'(q[0]), 32'd1);
        check("resume q1", 32'(q[1]), 32'd2);
        check("resume ovf", 32'(ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
